// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand-fetch stage: op codes, widths,
// the buffered operand bundle and the immediate-extension helper.
package alu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [2:0]        aluop;
        logic [REG_AW-1:0] rd;
        logic              we;
    } alu_bundle_t;

    function automatic logic [XLEN-1:0] extend_imm(input logic [15:0] imm, input logic sext);
        return sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// DEPTH-entry synchronous FIFO of operand bundles; head is read straight
// from storage so it holds steady while the consumer stalls.
module alu_op_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  alu_bundle_t din,
    input  logic        pop,
    output alu_bundle_t dout,
    output logic        full,
    output logic        empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    alu_bundle_t   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    // a pop in the same edge frees the slot a push into a full FIFO needs
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: register file, pending-write scoreboard and output FIFO.
// Optional stall counter port enabled by ALU_STAGE_STALL_CNT_EN.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_rs,
    input  logic [4:0]      req_rt,
    input  logic [15:0]     req_imm,
    input  logic            req_use_imm,
    input  logic            req_sext,
    input  logic [2:0]      req_aluop,
    input  logic [4:0]      req_rd,
    input  logic            req_we,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_A,
    output logic [XLEN-1:0] out_B,
    output logic [2:0]      out_ALUOp,
    output logic [4:0]      out_rd,
    output logic            out_we,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data
`ifdef ALU_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] regs_r [32];
    logic [31:0]     pending_r;
    logic [31:0]     clear_mask_s;
    logic [31:0]     set_mask_s;
    logic [31:0]     busy_s;
    logic [XLEN-1:0] rs_data_s;
    logic [XLEN-1:0] rt_data_s;
    logic            hazard_s;
    logic            accept_s;
    logic            pop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;
    alu_bundle_t     push_data_s;
    alu_bundle_t     head_s;

    // a write-back landing this cycle clears its pending bit before the hazard check
    assign clear_mask_s = wb_en ? (32'd1 << wb_addr) : 32'd0;
    assign busy_s       = pending_r & ~clear_mask_s & ~32'd1;
    assign hazard_s     = busy_s[req_rs] | (~req_use_imm & busy_s[req_rt]) | (req_we & busy_s[req_rd]);

    assign pop_s      = out_ready && !fifo_empty_s;
    assign req_ready  = (!fifo_full_s || pop_s) && !hazard_s;
    assign accept_s   = req_valid && req_ready;
    assign set_mask_s = (accept_s && req_we && (req_rd != 5'd0)) ? (32'd1 << req_rd) : 32'd0;

    // register reads with same-cycle write-back bypass; r0 is hardwired zero
    always_comb begin
        rs_data_s = {XLEN{1'b0}};
        rt_data_s = {XLEN{1'b0}};
        if (req_rs == 5'd0) begin
            rs_data_s = {XLEN{1'b0}};
        end else if (wb_en && (wb_addr == req_rs)) begin
            rs_data_s = wb_data;
        end else begin
            rs_data_s = regs_r[req_rs];
        end
        if (req_rt == 5'd0) begin
            rt_data_s = {XLEN{1'b0}};
        end else if (wb_en && (wb_addr == req_rt)) begin
            rt_data_s = wb_data;
        end else begin
            rt_data_s = regs_r[req_rt];
        end
    end

    assign push_data_s.a     = rs_data_s;
    assign push_data_s.b     = req_use_imm ? extend_imm(req_imm, req_sext) : rt_data_s;
    assign push_data_s.aluop = req_aluop;
    assign push_data_s.rd    = req_rd;
    assign push_data_s.we    = req_we;

    // register file write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            regs_r[wb_addr] <= wb_data;
        end else begin
            regs_r[0] <= {XLEN{1'b0}};
        end
    end

    // scoreboard: a new reservation outranks a same-cycle clear of that register
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= 32'd0;
        end else begin
            pending_r <= (pending_r & ~clear_mask_s) | set_mask_s;
        end
    end

    alu_op_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept_s),
        .din   (push_data_s),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign out_valid = !fifo_empty_s;
    assign out_A     = head_s.a;
    assign out_B     = head_s.b;
    assign out_ALUOp = head_s.aluop;
    assign out_rd    = head_s.rd;
    assign out_we    = head_s.we;

`ifdef ALU_STAGE_STALL_CNT_EN
    // count cycles a presented request is held off
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
        end else if (req_valid && !req_ready) begin
            stall_cycles <= stall_cycles + 32'd1;
        end else begin
            stall_cycles <= stall_cycles;
        end
    end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a randomized
// run against a queue/array reference model.
module tb_alu_operand_stage;
    import alu_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_use_imm, req_sext, req_we;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [15:0] req_imm;
    logic [2:0]  req_aluop;
    logic        out_valid, out_ready, out_we;
    logic [31:0] out_A, out_B;
    logic [2:0]  out_ALUOp;
    logic [4:0]  out_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
`ifdef ALU_STAGE_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    alu_bundle_t m_q [$];

    alu_operand_stage #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_rt(req_rt),
        .req_imm(req_imm), .req_use_imm(req_use_imm), .req_sext(req_sext),
        .req_aluop(req_aluop), .req_rd(req_rd), .req_we(req_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_A(out_A), .out_B(out_B),
        .out_ALUOp(out_ALUOp), .out_rd(out_rd), .out_we(out_we),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
`ifdef ALU_STAGE_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        return (a != 5'd0) && m_pend[a] && !(wb_en && wb_addr == a);
    endfunction

    function automatic bit m_ready();
        bit full_blocked, haz;
        full_blocked = (m_q.size() >= DEPTH) && !out_ready;
        haz = m_busy(req_rs) || (!req_use_imm && m_busy(req_rt)) || (req_we && m_busy(req_rd));
        return !full_blocked && !haz;
    endfunction

    // advance one clock and update the reference model with what that edge does
    task automatic tick();
        bit acc, pop;
        alu_bundle_t nb;
        acc = req_valid && m_ready();
        pop = out_ready && (m_q.size() > 0);
        nb.a = m_read(req_rs);
        nb.b = req_use_imm ? (req_sext ? 32'($signed(req_imm)) : 32'(req_imm)) : m_read(req_rt);
        nb.aluop = req_aluop;
        nb.rd = req_rd;
        nb.we = req_we;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_pend[i] = 1'b0;
            end
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(nb);
            if (wb_en) begin
                m_pend[wb_addr] = 1'b0;
                if (wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
            end
            if (acc && req_we && req_rd != 5'd0) m_pend[req_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic set_req(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [15:0] imm, input logic ui, input logic sx,
                           input logic [2:0] op, input logic [4:0] rd, input logic we);
        req_valid = v; req_rs = rs; req_rt = rt; req_imm = imm; req_use_imm = ui;
        req_sext = sx; req_aluop = op; req_rd = rd; req_we = we;
    endtask

    task automatic idle();
        set_req(1'b0, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 3'b000, 5'd0, 1'b0);
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    endtask

    task automatic test_reset();
        idle();
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++;
        if ({out_A, out_B, out_ALUOp, out_rd, out_we} !== 73'd0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {out_A, out_B, out_ALUOp, out_rd, out_we});
        end
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_sext_bypass();
        set_req(1'b1, 5'd0, 5'd0, 16'hFFFF, 1'b1, 1'b1, ALU_ADD, 5'd3, 1'b1);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL sext_ready got=%b exp=1", req_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_A !== 32'd0 || out_B !== 32'hFFFF_FFFF || out_rd !== 5'd3) begin
            failures++; $display("FAIL sext_head got=%b/%h/%h/%0d exp=1/0/ffffffff/3", out_valid, out_A, out_B, out_rd);
        end
        set_req(1'b1, 5'd3, 5'd0, 16'h0001, 1'b1, 1'b0, ALU_SUB, 5'd4, 1'b1);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL raw_stall got=%b exp=0", req_ready); end
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL raw_wb_unstall got=%b exp=1", req_ready); end
        tick();
        idle();
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_A !== 32'h1234 || out_ALUOp !== ALU_SUB) begin
            failures++; $display("FAIL bypass_head got=%b/%h/%b exp=1/1234/001", out_valid, out_A, out_ALUOp);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h55;
        tick();
        idle();
    endtask

    task automatic test_fifo_full();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 5'd0, 5'd0, 16'(i), 1'b1, 1'b0, ALU_OR, 5'(i + 8), 1'b0);
            #1;
            checks++;
            if (req_ready !== (i < 2)) begin
                failures++; $display("FAIL full_ready_%0d got=%b exp=%b", i, req_ready, (i < 2));
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL full_pushpop_ready got=%b exp=1", req_ready); end
        tick();
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_B !== 32'd1 || out_rd !== 5'd9) begin
            failures++; $display("FAIL order_second got=%b/%h/%0d exp=1/1/9", out_valid, out_B, out_rd);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_B !== 32'd2 || out_rd !== 5'd10) begin
            failures++; $display("FAIL order_third got=%b/%h/%0d exp=1/2/10", out_valid, out_B, out_rd);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL full_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_reg0();
        idle();
        out_ready = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
        tick();
        idle();
        set_req(1'b1, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, ALU_AND, 5'd0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_A !== 32'd0 || out_B !== 32'd0) begin
            failures++; $display("FAIL r0_read got=%b/%h/%h exp=1/0/0", out_valid, out_A, out_B);
        end
        set_req(1'b1, 5'd0, 5'd0, 16'h7, 1'b0, 1'b0, ALU_AND, 5'd0, 1'b1);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL r0_nostall got=%b exp=1", req_ready); end
        tick();
        idle();
        tick();
        tick();
    endtask

    task automatic test_waw_reset();
        idle();
        out_ready = 1'b0;
        set_req(1'b1, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, ALU_SRL, 5'd5, 1'b1);
        tick();
        set_req(1'b1, 5'd0, 5'd0, 16'h1, 1'b1, 1'b0, ALU_SRA, 5'd5, 1'b1);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL waw_stall got=%b exp=0", req_ready); end
        tick();
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL waw_hold got=%b exp=0", req_ready); end
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h77;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL waw_release got=%b exp=1", req_ready); end
        tick();
        wb_en = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL set_wins got=%b exp=0", req_ready); end
        idle();
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", out_valid); end
        set_req(1'b1, 5'd5, 5'd5, 16'h0, 1'b0, 1'b0, ALU_ADD, 5'd5, 1'b1);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL midreset_pending got=%b exp=1", req_ready); end
        idle();
    endtask

`ifdef ALU_STAGE_STALL_CNT_EN
    task automatic test_stall_cnt();
        idle();
        out_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (stall_cycles !== 32'd0) begin failures++; $display("FAIL stall_reset got=%0d exp=0", stall_cycles); end
        set_req(1'b1, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, ALU_ADD, 5'd7, 1'b1);
        tick();
        set_req(1'b1, 5'd7, 5'd0, 16'h0, 1'b1, 1'b0, ALU_ADD, 5'd1, 1'b0);
        repeat (7) tick();
        idle();
        #1;
        checks++;
        if (stall_cycles !== 32'd7) begin failures++; $display("FAIL stall_count got=%0d exp=7", stall_cycles); end
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'd0;
        tick();
        idle();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 79) == 0);
            req_valid   = ($urandom_range(0, 3) != 0);
            req_rs      = 5'($urandom_range(0, 7));
            req_rt      = 5'($urandom_range(0, 7));
            req_rd      = 5'($urandom_range(0, 7));
            req_imm     = 16'($urandom);
            req_use_imm = 1'($urandom);
            req_sext    = 1'($urandom);
            req_aluop   = 3'($urandom_range(0, 5));
            req_we      = 1'($urandom);
            out_ready   = 1'($urandom);
            wb_en       = ($urandom_range(0, 2) == 0);
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            #1;
            checks++;
            if (req_ready !== m_ready()) begin
                failures++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, req_ready, m_ready());
            end
            checks++;
            if (out_valid !== (m_q.size() > 0)) begin
                failures++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, out_valid, (m_q.size() > 0));
            end else if (m_q.size() > 0) begin
                checks++;
                if ({out_A, out_B, out_ALUOp, out_rd, out_we} !== m_q[0]) begin
                    failures++; $display("FAIL rand_head n=%0d got=%h exp=%h", n,
                                         {out_A, out_B, out_ALUOp, out_rd, out_we}, m_q[0]);
                end
            end
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        idle();
        test_reset();
        test_sext_bypass();
        test_fifo_full();
        test_reg0();
        test_waw_reset();
`ifdef ALU_STAGE_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
